// File: rtl/getir_asamasi_pkg.sv
// Shared definitions for the fetch stage: FSM states, branch opcode, PC step.
// Also holds the PC word-alignment helper used for every externally supplied target.
package getir_asamasi_pkg;

   typedef enum logic {
      ISTE  = 1'b0,
      BEKLE = 1'b1
   } durum_t;

   localparam logic [6:0]  OPC_DALLAN      = 7'b1100011;
   localparam logic [31:0] PS_ADIM         = 32'd4;
   localparam int          TAMPON_GENISLIK = 65;

   function automatic logic [31:0] hizala(input logic [31:0] hedef);
      return hedef & ~32'd3;
   endfunction

endpackage

// File: rtl/getir_tamponu.sv
// Synchronous FIFO between fetch and decode; entries are {PC, instruction, taken}.
// Flush clears the pointers and the count and overrides any same-cycle push or pop.
module getir_tamponu #(
   parameter int DATA_W       = 65,
   parameter int TAMPON_DERIN = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            it,
   input  logic                            cek,
   input  logic                            temizle,
   input  logic [DATA_W-1:0]               giris,
   output logic [DATA_W-1:0]               cikis,
   output logic [$clog2(TAMPON_DERIN):0]   sayi,
   output logic                            bos,
   output logic                            dolu
);
   localparam int AW = $clog2(TAMPON_DERIN);
   localparam int SW = AW + 1;

   logic [DATA_W-1:0] bellek [TAMPON_DERIN];
   logic [AW-1:0]     bas;
   logic [AW-1:0]     son;

   always_ff @(posedge clk) begin
      if (rst || temizle) begin
         bas  <= '0;
         son  <= '0;
         sayi <= '0;
      end else begin
         if (it)
            son <= son + AW'(1);
         if (cek)
            bas <= bas + AW'(1);
         if (it && !cek)
            sayi <= sayi + SW'(1);
         else if (cek && !it)
            sayi <= sayi - SW'(1);
      end
   end

   // Storage carries data only and is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (it && !temizle)
         bellek[son] <= giris;
   end

   assign cikis = bellek[bas];
   assign bos   = (sayi == '0);
   assign dolu  = (sayi == SW'(TAMPON_DERIN));

endmodule

// File: rtl/getir_asamasi.sv
// Fetch stage: owns the PC, keeps one instruction-memory read in flight, consults the
// predictor on each returned instruction and queues {PC, instruction, taken} for decode.
module getir_asamasi
   import getir_asamasi_pkg::*;
#(
   parameter logic [31:0] RESET_PS     = 32'h0000_0000,
   parameter int          TAMPON_DERIN = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        bellek_istek_gecerli,
   input  logic        bellek_istek_hazir,
   output logic [31:0] bellek_istek_adres,
   input  logic        bellek_yanit_gecerli,
   input  logic [31:0] bellek_yanit_buyruk,
   output logic        ongorucu_gecerli,
   output logic [31:0] ongorucu_ps,
   output logic [31:0] ongorucu_buyruk,
   input  logic        ongorucu_dallan,
   input  logic [31:0] ongorucu_dallan_ps,
   input  logic        yurut_yonlendir,
   input  logic [31:0] yurut_yonlendir_ps,
   output logic        coz_gecerli,
   input  logic        coz_hazir,
   output logic [31:0] coz_ps,
   output logic [31:0] coz_buyruk,
   output logic        coz_tahmin_dallan
);
   localparam int SW = $clog2(TAMPON_DERIN) + 1;

   durum_t durum;
   durum_t durum_sonraki;
   logic [31:0] ps;
   logic        atla;

   logic [SW-1:0]              sayi;
   logic                       bos;
   logic                       dolu;
   logic [TAMPON_GENISLIK-1:0] giris;
   logic [TAMPON_GENISLIK-1:0] cikis;

   logic yer_var;
   logic istek_kabul;
   logic yanit_al;
   logic tahmin;
   logic it;
   logic cek;

   // A request needs a free slot for its response, counting entries already queued.
   assign yer_var     = (int'(sayi) + 1) <= TAMPON_DERIN;
   assign istek_kabul = bellek_istek_gecerli && bellek_istek_hazir;
   assign yanit_al    = !rst && (durum == BEKLE) && bellek_yanit_gecerli
                        && !atla && !yurut_yonlendir;
   assign tahmin      = ongorucu_dallan && (bellek_yanit_buyruk[6:0] == OPC_DALLAN);
   assign it          = yanit_al && !dolu;
   assign cek         = coz_gecerli && coz_hazir && !yurut_yonlendir;
   assign giris       = {ps, bellek_yanit_buyruk, tahmin};

   getir_tamponu #(
      .DATA_W       (TAMPON_GENISLIK),
      .TAMPON_DERIN (TAMPON_DERIN)
   ) u_tampon (
      .clk     (clk),
      .rst     (rst),
      .it      (it),
      .cek     (cek),
      .temizle (yurut_yonlendir),
      .giris   (giris),
      .cikis   (cikis),
      .sayi    (sayi),
      .bos     (bos),
      .dolu    (dolu)
   );

   always_ff @(posedge clk) begin
      if (rst)
         durum <= ISTE;
      else
         durum <= durum_sonraki;
   end

   // A redirect while a read is still out leaves us waiting for it so it can be dropped.
   always_comb begin
      durum_sonraki = durum;
      if (yurut_yonlendir)
         durum_sonraki = ((durum == BEKLE) && !bellek_yanit_gecerli) ? BEKLE : ISTE;
      else if (durum == ISTE) begin
         if (istek_kabul)
            durum_sonraki = BEKLE;
      end else if (bellek_yanit_gecerli)
         durum_sonraki = ISTE;
   end

   always_comb begin
      bellek_istek_gecerli = 1'b0;
      bellek_istek_adres   = '0;
      ongorucu_gecerli     = 1'b0;
      ongorucu_ps          = '0;
      ongorucu_buyruk      = '0;
      coz_gecerli          = 1'b0;
      coz_ps               = '0;
      coz_buyruk           = '0;
      coz_tahmin_dallan    = 1'b0;
      if (!rst) begin
         bellek_istek_gecerli = (durum == ISTE) && yer_var && !yurut_yonlendir;
         bellek_istek_adres   = ps;
         ongorucu_gecerli     = yanit_al;
         ongorucu_ps          = ps;
         ongorucu_buyruk      = bellek_yanit_buyruk;
         coz_gecerli          = !bos;
         if (!bos)
            {coz_ps, coz_buyruk, coz_tahmin_dallan} = cikis;
      end
   end

   // A discarded response leaves PC untouched: it already holds the redirect target.
   always_ff @(posedge clk) begin
      if (rst) begin
         ps   <= RESET_PS;
         atla <= 1'b0;
      end else if (yurut_yonlendir) begin
         ps   <= hizala(yurut_yonlendir_ps);
         atla <= (durum == BEKLE) && !bellek_yanit_gecerli;
      end else if ((durum == BEKLE) && bellek_yanit_gecerli) begin
         atla <= 1'b0;
         if (!atla)
            ps <= tahmin ? hizala(ongorucu_dallan_ps) : ps + PS_ADIM;
      end
   end

endmodule

// File: tb/tb_getir_asamasi.sv
// Bench for getir_asamasi: memory/predictor/decode stand-ins plus a transaction-level
// model of the fetch stream (expected next PC, outstanding read, queue of decode entries).
module tb_getir_asamasi;
   localparam logic [31:0] RPS = 32'h0000_0000;
   localparam int          D   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        bellek_istek_gecerli;
   logic        bellek_istek_hazir;
   logic [31:0] bellek_istek_adres;
   logic        bellek_yanit_gecerli;
   logic [31:0] bellek_yanit_buyruk;
   logic        ongorucu_gecerli;
   logic [31:0] ongorucu_ps;
   logic [31:0] ongorucu_buyruk;
   logic        ongorucu_dallan;
   logic [31:0] ongorucu_dallan_ps;
   logic        yurut_yonlendir;
   logic [31:0] yurut_yonlendir_ps;
   logic        coz_gecerli;
   logic        coz_hazir;
   logic [31:0] coz_ps;
   logic [31:0] coz_buyruk;
   logic        coz_tahmin_dallan;

   always #5 clk = ~clk;

   getir_asamasi #(.RESET_PS(RPS), .TAMPON_DERIN(D)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .bellek_istek_gecerli (bellek_istek_gecerli),
      .bellek_istek_hazir   (bellek_istek_hazir),
      .bellek_istek_adres   (bellek_istek_adres),
      .bellek_yanit_gecerli (bellek_yanit_gecerli),
      .bellek_yanit_buyruk  (bellek_yanit_buyruk),
      .ongorucu_gecerli     (ongorucu_gecerli),
      .ongorucu_ps          (ongorucu_ps),
      .ongorucu_buyruk      (ongorucu_buyruk),
      .ongorucu_dallan      (ongorucu_dallan),
      .ongorucu_dallan_ps   (ongorucu_dallan_ps),
      .yurut_yonlendir      (yurut_yonlendir),
      .yurut_yonlendir_ps   (yurut_yonlendir_ps),
      .coz_gecerli          (coz_gecerli),
      .coz_hazir            (coz_hazir),
      .coz_ps               (coz_ps),
      .coz_buyruk           (coz_buyruk),
      .coz_tahmin_dallan    (coz_tahmin_dallan)
   );

   int checks = 0;
   int errors = 0;

   // stimulus knobs
   int          hazir_pct, coz_pct, redir_pct, lat_min, lat_max;
   bit          rastgele, rst_req, redir_now, redir_on_resp;
   logic [31:0] redir_hedef;

   // memory stand-in, driven by the DUT's actual handshakes
   bit          mem_busy;
   int          mem_wait;
   logic [31:0] mem_addr;
   logic [31:0] req_log[$];

   // reference model
   logic [31:0] m_pc, m_addr;
   bit          m_out, m_skip;
   logic [64:0] m_q[$];
   logic [64:0] pop_log[$];

   task automatic chk(input string ad, input logic [64:0] gercek, input logic [64:0] beklenen);
      checks++;
      if (gercek !== beklenen) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", ad, gercek, beklenen, $time);
      end
   endtask

   task automatic chk_req(input string ad, input int i, input logic [31:0] bek);
      if (i >= req_log.size()) begin
         checks++; errors++;
         $display("FAIL %s: request #%0d never issued, expected %h", ad, i, bek);
      end else
         chk(ad, {33'b0, req_log[i]}, {33'b0, bek});
   endtask

   task automatic chk_pop(input string ad, input int i, input logic [64:0] bek);
      if (i >= pop_log.size()) begin
         checks++; errors++;
         $display("FAIL %s: entry #%0d never consumed, expected %h", ad, i, bek);
      end else
         chk(ad, pop_log[i], bek);
   endtask

   task automatic drive();
      logic [6:0]  opc;
      logic [31:0] tmp;
      rst                  = rst_req;
      bellek_istek_hazir   = ($urandom_range(0, 99) < hazir_pct);
      bellek_yanit_gecerli = 1'b0;
      if (mem_busy) begin
         if (mem_wait > 0) mem_wait--;
         bellek_yanit_gecerli = (mem_wait == 0);
      end
      if (rastgele) begin
         case ($urandom_range(0, 3))
            0, 1:    opc = 7'b1100011;
            2:       opc = 7'b0010011;
            default: opc = 7'($urandom);
         endcase
         tmp                 = $urandom;
         bellek_yanit_buyruk = {tmp[31:7], opc};
         ongorucu_dallan     = 1'($urandom_range(0, 1));
         ongorucu_dallan_ps  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
      end else begin
         bellek_yanit_buyruk = (mem_addr == 32'h10) ? 32'h0080_0063 : 32'h0000_0013;
         ongorucu_dallan     = (mem_addr == 32'h10) || (mem_addr == 32'h20);
         ongorucu_dallan_ps  = (mem_addr == 32'h10) ? 32'h18 : 32'h40;
      end
      coz_hazir = ($urandom_range(0, 99) < coz_pct);
      if (redir_now || (redir_on_resp && bellek_yanit_gecerli)) begin
         yurut_yonlendir    = 1'b1;
         yurut_yonlendir_ps = redir_hedef;
         redir_now          = 1'b0;
         redir_on_resp      = 1'b0;
      end else begin
         yurut_yonlendir    = rastgele && ($urandom_range(0, 99) < redir_pct);
         yurut_yonlendir_ps = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
      end
   endtask

   // Checks this cycle's outputs against the model, then advances the model one clock.
   task automatic model_step();
      bit          exp_ist, resp, exp_ong, pop, tk;
      logic [31:0] b;
      if (rst) begin
         chk("rst_istek", bellek_istek_gecerli, 0);
         chk("rst_adres", bellek_istek_adres, 0);
         chk("rst_ong", {ongorucu_gecerli, ongorucu_ps, ongorucu_buyruk}, 0);
         chk("rst_coz", {coz_gecerli, coz_ps, coz_buyruk, coz_tahmin_dallan}, 0);
         m_pc = RPS; m_out = 0; m_skip = 0; m_q.delete();
         return;
      end
      exp_ist = !m_out && (m_q.size() < D) && !yurut_yonlendir;
      chk("istek_gecerli", bellek_istek_gecerli, exp_ist);
      if (exp_ist) chk("istek_adres", bellek_istek_adres, m_pc);
      resp    = m_out && bellek_yanit_gecerli;
      exp_ong = resp && !m_skip && !yurut_yonlendir;
      chk("ongorucu_gecerli", ongorucu_gecerli, exp_ong);
      if (exp_ong) chk("ongorucu_ps_buyruk", {ongorucu_ps, ongorucu_buyruk}, {m_addr, bellek_yanit_buyruk});
      chk("coz_gecerli", coz_gecerli, m_q.size() != 0);
      if (m_q.size() != 0) chk("coz_giris", {coz_ps, coz_buyruk, coz_tahmin_dallan}, m_q[0]);
      pop = (m_q.size() != 0) && coz_hazir;
      if (yurut_yonlendir) begin
         m_q.delete();
         m_pc   = {yurut_yonlendir_ps[31:2], 2'b00};
         m_skip = m_out && !resp;
         if (resp) m_out = 0;
      end else begin
         if (pop) pop_log.push_back(m_q.pop_front());
         if (resp) begin
            m_out = 0;
            if (m_skip) m_skip = 0;
            else begin
               b  = bellek_yanit_buyruk;
               tk = ongorucu_dallan && (b[6:0] == 7'b1100011);
               m_q.push_back({m_addr, b, tk});
               m_pc = tk ? {ongorucu_dallan_ps[31:2], 2'b00} : m_addr + 32'd4;
            end
         end
         if (exp_ist && bellek_istek_hazir) begin
            m_out  = 1;
            m_addr = m_pc;
         end
      end
   endtask

   task automatic mem_step();
      if (rst) begin
         mem_busy = 0;
         return;
      end
      if (mem_busy && bellek_yanit_gecerli) mem_busy = 0;
      if (bellek_istek_gecerli && bellek_istek_hazir) begin
         if (mem_busy) chk("tek_istek", 1, 0);
         mem_busy = 1;
         mem_addr = bellek_istek_adres;
         mem_wait = $urandom_range(lat_min, lat_max);
         req_log.push_back(bellek_istek_adres);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      model_step();
      mem_step();
   endtask

   task automatic run_until_reqs(input int hedef, input string ad);
      int n = 0;
      while (req_log.size() < hedef && n < 200) begin
         cycle();
         n++;
      end
      checks++;
      if (req_log.size() < hedef) begin
         errors++;
         $display("FAIL %s: timeout with %0d requests, needed %0d", ad, req_log.size(), hedef);
      end
   endtask

   task automatic wait_accept(input string ad);
      int n = 0;
      while (!(mem_busy && mem_wait == lat_max) && n < 200) begin
         cycle();
         n++;
      end
      checks++;
      if (!(mem_busy && mem_wait == lat_max)) begin
         errors++;
         $display("FAIL %s: timeout waiting for an accepted request", ad);
      end
   endtask

   initial begin
      int n;
      hazir_pct = 100; coz_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;
      rastgele = 0; rst_req = 1; redir_now = 0; redir_on_resp = 0; redir_hedef = '0;
      mem_busy = 0; mem_wait = 0; mem_addr = '1;
      m_pc = RPS; m_addr = '0; m_out = 0; m_skip = 0;
      rst = 1; bellek_istek_hazir = 0; bellek_yanit_gecerli = 0; bellek_yanit_buyruk = '0;
      ongorucu_dallan = 0; ongorucu_dallan_ps = '0; yurut_yonlendir = 0;
      yurut_yonlendir_ps = '0; coz_hazir = 0;

      repeat (2) cycle();
      chk("rst_istek_lit", bellek_istek_gecerli, 0);
      rst_req = 0;
      cycle();
      chk("ilk_istek_lit", {bellek_istek_gecerli, bellek_istek_adres}, {1'b1, 32'h0});

      // sequential fetch, taken branch at 0x10, ignored prediction on ADDI at 0x20
      run_until_reqs(9, "t1_zaman");
      repeat (4) cycle();
      chk_req("t1_adres0", 0, 32'h00);
      chk_req("t1_adres1", 1, 32'h04);
      chk_req("t1_adres2", 2, 32'h08);
      chk_req("t1_adres4", 4, 32'h10);
      chk_req("t2_hedef", 5, 32'h18);
      chk_req("t2_sonra", 6, 32'h1C);
      chk_req("t3_addi_ps4", 8, 32'h24);
      chk_pop("t1_giris0", 0, {32'h0, 32'h0000_0013, 1'b0});
      chk_pop("t2_dallan_giris", 4, {32'h10, 32'h0080_0063, 1'b1});
      chk_pop("t3_addi_giris", 7, {32'h20, 32'h0000_0013, 1'b0});

      // decode stalls: fetch stops once the buffer is full, resumes on release
      coz_pct = 0;
      repeat (12) cycle();
      chk("t4_istek_durdu", bellek_istek_gecerli, 0);
      chk("t4_coz_dolu", coz_gecerli, 1);
      coz_pct = 100;
      n = req_log.size();
      repeat (12) cycle();
      chk("t4_devam", req_log.size() > n, 1);

      // redirect while waiting: stale response dropped, then a redirect on that response
      lat_min = 3; lat_max = 3;
      wait_accept("t5a_kabul");
      redir_hedef = 32'h200; redir_now = 1;
      cycle();
      chk("t5_istek_bastirildi", bellek_istek_gecerli, 0);
      n = req_log.size();
      cycle();
      chk("t5_tampon_bos", coz_gecerli, 0);
      run_until_reqs(n + 1, "t5a_zaman");
      chk_req("t5_yeni_adres", n, 32'h200);
      wait_accept("t5b_kabul");
      redir_hedef = 32'h200; redir_now = 1;
      cycle();
      redir_hedef = 32'h300; redir_on_resp = 1;
      n = req_log.size();
      run_until_reqs(n + 1, "t5b_zaman");
      chk_req("t5_ikinci_yonlendirme", n, 32'h300);

      // redirect in ISTE with a pending pop and a would-be request; PC wrap
      lat_min = 1; lat_max = 1; coz_pct = 0;
      n = 0;
      while (!(m_q.size() == 1 && !mem_busy) && n < 200) begin cycle(); n++; end
      chk("t6_hazirlik", m_q.size() == 1 && !mem_busy, 1);
      coz_pct = 100; redir_hedef = 32'hFFFF_FFFE; redir_now = 1;
      n = req_log.size();
      cycle();
      chk("t6_istek_bastirildi", bellek_istek_gecerli, 0);
      cycle();
      chk("t6_tampon_bos", coz_gecerli, 0);
      run_until_reqs(n + 2, "t6_zaman");
      chk_req("t6_hedef", n, 32'hFFFF_FFFC);
      chk_req("t6_sarma", n + 1, 32'h0);
      wait_accept("t6b_kabul");
      redir_hedef = 32'h400; redir_on_resp = 1;
      n = req_log.size();
      run_until_reqs(n + 1, "t6b_zaman");
      chk_req("t6_yanit_yonlendirme", n, 32'h400);

      // randomized traffic with one mid-stream reset
      rastgele = 1; hazir_pct = 70; coz_pct = 60; redir_pct = 5; lat_min = 1; lat_max = 3;
      repeat (1500) cycle();
      rst_req = 1;
      cycle();
      rst_req = 0;
      repeat (1500) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
